comparador_serial_der_izq: RTL
==============================

COMPARADOR_SERIAL_DER_IZQ -- requirements
Module: comparador_serial_der_izq

Interface
REQ-001 Parameter N, default 8, word width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin comparing a new word pair.
REQ-005 valid  input  1  Ai/Bi carry a bit pair this cycle.
REQ-006 Ai  input  1  bit of word A, delivered LSB first.
REQ-007 Bi  input  1  bit of word B, delivered LSB first.
REQ-008 ready  output  1  block accepts a bit pair this cycle.
REQ-009 done  output  1  one-cycle pulse: result valid and just updated.
REQ-010 mayor  output  1  last completed comparison: A > B.
REQ-011 menor  output  1  last completed comparison: A < B.
REQ-012 igual  output  1  last completed comparison: A == B.
REQ-013 estado  output  2  running comparison state (a=01, b=10, c=11).

Function
REQ-014 Control FSM SHALL have states IDLE, RECIBIR, FIN.
- IDLE -> RECIBIR on start=1.
- RECIBIR -> FIN on the accepted pair that makes the count N.
- FIN -> IDLE unconditionally after one cycle.
REQ-015 On the IDLE->RECIBIR edge: estado := a (01), bit count := 0.
REQ-016 ready SHALL be 1 exactly while in RECIBIR; a pair is accepted only when ready=1 and valid=1.
REQ-017 Per accepted pair (right-to-left rule, higher-order bits override):
- Ai==Bi: estado unchanged.
- Ai=1, Bi=0: estado := b.
- Ai=0, Bi=1: estado := c.
REQ-018 Each accepted pair SHALL increment the bit count by 1. Cycles with valid=0 in RECIBIR change nothing.
REQ-019 On entering FIN, mayor/menor/igual SHALL be registered one-hot from the final estado (b->mayor, c->menor, a->igual), and done SHALL be 1 for exactly that cycle.
REQ-020 Latency: done asserts the cycle after the N-th accepted pair; with valid held at 1, done asserts N+1 cycles after start is sampled.
REQ-021 mayor/menor/igual SHALL hold their value until the next FIN; estado SHALL hold after FIN until the next start.
REQ-022 Boundaries:
- start while in RECIBIR or FIN is ignored.
- valid while in IDLE or FIN is ignored; no pair is lost or double-counted.
- N=1: a single accepted pair leads to FIN.

Reset
REQ-023 reset=1 SHALL immediately and asynchronously force:
- FSM to IDLE, count to 0, estado to a (01);
- ready, done, mayor, menor and igual to 0.
REQ-024 Reset asserted mid-word SHALL discard the partial word; after release, no done appears until a new start and N further pairs.

Structure
REQ-025 The state encodings a=01, b=10, c=11 and the FSM state codes SHALL live in a shared package or include file, reused by the left-to-right comparator.
REQ-026 The per-bit next-state rule SHALL be a combinational sub-module celda_tipica_der_izq (inputs p, q, Ai, Bi; outputs P, Q), registered by the top.
REQ-027 Control FSM, counter and result registers SHALL stay in the top module.

Verification (N=8)
REQ-028 A=0x5A, B=0x5A, valid held high -> done after 9 cycles, igual=1, mayor=menor=0.
REQ-029 A=0x80, B=0x7F -> estado goes c after bit 0 and b after bit 7; mayor=1.
REQ-030 A=0x01, B=0x02 with valid low on alternate cycles -> menor=1; done only after the 8th accepted pair.
REQ-031 reset pulsed after 4 pairs of A=0xFF, B=0x00, then start and A=0x00, B=0xFF -> exactly one done, with menor=1.
REQ-032 start pulsed during RECIBIR, and valid driven during IDLE -> no effect on count, estado or timing of done.

Source files
------------

// File: rtl/comparador_serial_der_izq_pkg.sv
// Shared encodings for the serial comparators: comparison-state codes and
// control FSM state codes. The left-to-right comparator uses the same codes.
package comparador_serial_der_izq_pkg;

  // Comparison state: a = equal so far, b = A greater, c = A smaller
  localparam logic [1:0] EST_A = 2'b01;
  localparam logic [1:0] EST_B = 2'b10;
  localparam logic [1:0] EST_C = 2'b11;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RECIBIR = 2'b01;
  localparam logic [1:0] S_FIN     = 2'b10;

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// Per-bit next-state rule for the LSB-first comparator: a differing bit pair
// overrides everything seen so far, because it is of higher order.
module celda_tipica_der_izq (
  input  logic p,
  input  logic q,
  input  logic Ai,
  input  logic Bi,
  output logic P,
  output logic Q
);

  logic dif;

  assign dif = Ai ^ Bi;
  // Differing bits give b (10) when Ai=1 and c (11) when Bi=1
  assign P = dif | p;
  assign Q = dif ? Bi : q;

endmodule

// File: rtl/comparador_serial_der_izq.sv
// Serial magnitude comparator, words delivered LSB first. Control FSM, bit
// counter and result registers live here; the bit rule is in the cell.
module comparador_serial_der_izq
  import comparador_serial_der_izq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       valid,
  input  logic       Ai,
  input  logic       Bi,
  output logic       ready,
  output logic       done,
  output logic       mayor,
  output logic       menor,
  output logic       igual,
  output logic [1:0] estado
);

  localparam int CW = $clog2(N + 1);

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic [1:0]    est_nxt;
  logic          acc;
  logic          last;

  celda_tipica_der_izq u_celda (
    .p  (estado[1]),
    .q  (estado[0]),
    .Ai (Ai),
    .Bi (Bi),
    .P  (est_nxt[1]),
    .Q  (est_nxt[0])
  );

  assign ready = (st == S_RECIBIR);
  assign done  = (st == S_FIN);
  assign acc   = ready & valid;
  assign last  = acc && (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= S_IDLE;
      cnt    <= '0;
      estado <= EST_A;
      mayor  <= 1'b0;
      menor  <= 1'b0;
      igual  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (start) begin
            st     <= S_RECIBIR;
            estado <= EST_A;
            cnt    <= '0;
          end
        end
        S_RECIBIR: begin
          if (acc) begin
            estado <= est_nxt;
            cnt    <= cnt + CW'(1);
            // Results are taken from the cell output so they include the last pair
            if (last) begin
              st    <= S_FIN;
              mayor <= (est_nxt == EST_B);
              menor <= (est_nxt == EST_C);
              igual <= (est_nxt == EST_A);
            end
          end
        end
        S_FIN:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
